// File: rtl/alu_muldiv_seq_if.sv
// Request/result and ALU-drive bundle for the multiply/divide sequencer.
// Single-cycle signal grouping only, so it adds no latency.
// No backpressure: start is a pulse that the sequencer samples only when idle.
//
// master : requester plus the ALU (drives start/op/opa/opb and alu_Out/alu_Ofl)
// slave  : the sequencer (drives busy/done/results and all ALU control/operands)
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_InA;
  logic [WIDTH-1:0] alu_InB;
  logic             alu_Cin;
  logic [2:0]       alu_Oper;
  logic             alu_invA;
  logic             alu_invB;
  logic             alu_sign;
  logic [WIDTH-1:0] alu_Out;
  logic             alu_Ofl;

  modport master (
    output start, op, opa, opb, alu_Out, alu_Ofl,
    input  busy, done, result_hi, result_lo, div_by_zero,
    input  alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign
  );

  modport slave (
    input  start, op, opa, opb, alu_Out, alu_Ofl,
    output busy, done, result_hi, result_lo, div_by_zero,
    output alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned 16x16 shift-add multiply / 16/16 restoring divide reusing the shared ALU adder.
// Latency: start to done 17 cycles (16 RUN + 1 DONE); divide by zero 1 cycle.
// No backpressure or queuing: start is ignored outside IDLE; results hold until next accepted start.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries start/op/opa/opb,
// busy/done/result_hi/result_lo/div_by_zero, and the ALU operand/control outputs with
// alu_Out/alu_Ofl coming back from the ALU.
module alu_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [WIDTH-1:0]   a_q;      // partial product high half / partial remainder
  logic [WIDTH-1:0]   q_q;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   m_q;      // multiplicand / divisor
  logic               op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_hi_q;
  logic [WIDTH-1:0]   res_lo_q;
  logic               dbz_q;

  logic               start_div0;
  logic               last_iter;
  logic [WIDTH-1:0]   div_r;
  logic               div_accept;
  logic [WIDTH-1:0]   a_nxt;
  logic [WIDTH-1:0]   q_nxt;

  assign start_div0 = bus.start && bus.op && (bus.opb == '0);
  assign last_iter  = (cnt_q == '1);

  // Divide: shift one dividend bit into the remainder. The bit shifted out of
  // A (r16) means R already exceeds any 16-bit divisor, so subtraction is
  // accepted regardless of the adder carry.
  assign div_r      = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign div_accept = a_q[WIDTH-1] | bus.alu_Ofl;

  always_comb begin
    a_nxt = a_q;
    q_nxt = q_q;
    if (op_q) begin
      if (div_accept) begin
        a_nxt = bus.alu_Out;
        q_nxt = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        a_nxt = div_r;
        q_nxt = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Multiply: the adder carry becomes the new MSB of the 33-bit {C,A,Q} shift.
      if (q_q[0]) begin
        {a_nxt, q_nxt} = {bus.alu_Ofl, bus.alu_Out, q_q[WIDTH-1:1]};
      end else begin
        {a_nxt, q_nxt} = {1'b0, a_q, q_q[WIDTH-1:1]};
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = start_div0 ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the ALU is only driven with live operands while in RUN.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.alu_InA  = '0;
    bus.alu_InB  = '0;
    bus.alu_Cin  = 1'b0;
    bus.alu_invB = 1'b0;
    case (state_q)
      RUN: begin
        bus.busy    = 1'b1;
        bus.alu_InB = m_q;
        if (op_q) begin
          // R - M computed as R + ~M + 1
          bus.alu_InA  = div_r;
          bus.alu_invB = 1'b1;
          bus.alu_Cin  = 1'b1;
        end else begin
          bus.alu_InA  = a_q;
        end
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.alu_Oper    = 3'b100;
  assign bus.alu_invA    = 1'b0;
  assign bus.alu_sign    = 1'b0;
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (start_div0) begin
              res_lo_q <= '1;
              res_hi_q <= bus.opa;
              dbz_q    <= 1'b1;
            end else begin
              a_q   <= '0;
              q_q   <= bus.opa;
              m_q   <= bus.opb;
              op_q  <= bus.op;
              cnt_q <= '0;
              dbz_q <= 1'b0;
            end
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            res_hi_q <= a_nxt;
            res_lo_q <= q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU model, reference arithmetic model and a
// scoreboard queue drained by a done-triggered monitor.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_muldiv_seq_if bus_if ();

  alu_muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Behavioural shared ALU: add with optional operand inversion; other opcodes
  // deliberately give a different (XOR) answer.
  logic [15:0] alu_a_e;
  logic [15:0] alu_b_e;
  logic [16:0] alu_sum;
  always_comb begin
    alu_a_e = bus_if.alu_invA ? ~bus_if.alu_InA : bus_if.alu_InA;
    alu_b_e = bus_if.alu_invB ? ~bus_if.alu_InB : bus_if.alu_InB;
    alu_sum = {1'b0, alu_a_e} + {1'b0, alu_b_e} + {16'd0, bus_if.alu_Cin};
    if (bus_if.alu_Oper == 3'b100) begin
      bus_if.alu_Out = alu_sum[15:0];
      bus_if.alu_Ofl = bus_if.alu_sign ?
                       ((alu_a_e[15] == alu_b_e[15]) && (alu_sum[15] != alu_a_e[15])) :
                       alu_sum[16];
    end else begin
      bus_if.alu_Out = alu_a_e ^ alu_b_e;
      bus_if.alu_Ofl = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic exp_t model(input bit op, input logic [15:0] a, input logic [15:0] b,
                                 input int at);
    exp_t        e;
    logic [31:0] p;
    if (!op) begin
      p          = {16'd0, a} * {16'd0, b};
      e.hi       = p[31:16];
      e.lo       = p[15:0];
      e.dbz      = 1'b0;
      e.done_cyc = at + 17;
      e.busy_len = 16;
    end else if (b == 16'd0) begin
      e.hi       = a;
      e.lo       = 16'hFFFF;
      e.dbz      = 1'b1;
      e.done_cyc = at + 1;
      e.busy_len = 0;
    end else begin
      e.hi       = a % b;
      e.lo       = a / b;
      e.dbz      = 1'b0;
      e.done_cyc = at + 17;
      e.busy_len = 16;
    end
    return e;
  endfunction

  // Called just after a rising edge with the sequencer idle; returns one cycle later.
  task automatic issue(input bit op, input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back(model(op, a, b, cyc));
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.opa   = a;
    bus_if.opb   = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic pulse_start(input bit op, input logic [15:0] a, input logic [15:0] b);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.opa   = a;
    bus_if.opb   = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic run_op(input bit op, input logic [15:0] a, input logic [15:0] b);
    int lat;
    lat = (op && b == 16'd0) ? 1 : 17;
    issue(op, a, b);
    repeat (lat) @(posedge clk);
    #1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  // Monitor: compares on done, checks results hold otherwise, and checks reset values.
  logic [15:0] last_hi = '0;
  logic [15:0] last_lo = '0;
  int          busy_run = 0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_flags", {29'd0, bus_if.busy, bus_if.done, bus_if.div_by_zero}, 32'd0);
        chk("reset_results", {bus_if.result_hi, bus_if.result_lo}, 32'd0);
        last_hi  = '0;
        last_lo  = '0;
        busy_run = 0;
      end else begin
        if (bus_if.busy) busy_run++;
        if (bus_if.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("result_hi", {16'd0, bus_if.result_hi}, {16'd0, mon_e.hi});
            chk("result_lo", {16'd0, bus_if.result_lo}, {16'd0, mon_e.lo});
            chk("div_by_zero", {31'd0, bus_if.div_by_zero}, {31'd0, mon_e.dbz});
            chk("latency", cyc, mon_e.done_cyc);
            chk("busy_cycles", busy_run, mon_e.busy_len);
            last_hi = mon_e.hi;
            last_lo = mon_e.lo;
          end
          busy_run = 0;
        end else begin
          chk("result_hold", {bus_if.result_hi, bus_if.result_lo}, {last_hi, last_lo});
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    bit          rop;

    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = 1'b0;
    bus_if.opa   = '0;
    bus_if.opb   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(1'b0, 16'h0003, 16'h0005);
    run_op(1'b0, 16'hFFFF, 16'hFFFF);
    run_op(1'b1, 16'h0064, 16'h0007);
    run_op(1'b1, 16'hFFFF, 16'h0001);
    run_op(1'b1, 16'h8000, 16'h8001);
    run_op(1'b1, 16'h1234, 16'h0000);
    run_op(1'b0, 16'h0002, 16'h0002);

    // Starts during RUN (cycle 5) and during DONE must be ignored; a divide by
    // zero is used so an accepted start would produce an extra done.
    issue(1'b0, 16'h1234, 16'h5678);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(1'b1, 16'hABCD, 16'h0000);
    repeat (11) @(posedge clk);
    #1;
    pulse_start(1'b1, 16'h4321, 16'h0000);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts the multiply without a done.
    issue(1'b0, 16'h00FF, 16'h0F0F);
    repeat (7) @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 16'h0007, 16'h0009);

    // Randomized mix, including zero and small divisors
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      run_op(rop, ra, rb);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
